addsub_arbiter: RTL

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter_pkg.sv | 21 ++
 rtl/addsub_arbiter_addsub.sv | 24 ++
 rtl/addsub_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_pkg.sv
// Shared types and widths for the two-requester add/subtract arbiter.
package addsub_arbiter_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ID_W   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation captured from the granted requester
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              op;
        logic [ID_W-1:0]   id;
    } op_req_t;

endpackage

// File: rtl/addsub_arbiter_addsub.sv
// Shared 8-bit adder/subtractor: sum = A + (B ^ {op}) + op, cout reports carry (add) or borrow (sub).
module adder_subtractor_8bit
    import addsub_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              op,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    localparam int unsigned SUM_W = DATA_W + 1;

    logic [DATA_W-1:0] b_eff;
    logic [SUM_W-1:0]  total;

    always_comb begin
        b_eff = b ^ {DATA_W{op}};
        total = SUM_W'(a) + SUM_W'(b_eff) + SUM_W'(op);
        sum   = total[DATA_W-1:0];
        cout  = total[DATA_W] ^ op;
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter in front of one shared add/subtract datapath (IDLE -> EXEC -> RESP).
// Define ADDSUB_ARB_OVF_EN to add the registered signed-overflow output rsp_ovf.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int unsigned PRIO_FIXED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req0_op,
    input  logic              req1_op,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_sum,
    output logic              rsp_cout,
`ifdef ADDSUB_ARB_OVF_EN
    output logic              rsp_ovf,
`endif
    output logic [ID_W-1:0]   rsp_id
);

    state_t            state;
    state_t            next_state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant_id;
    logic              accept;
    op_req_t           sel;
    op_req_t           held;
    logic [DATA_W-1:0] alu_sum;
    logic              alu_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant selection is combinational so the winner sees ready in the same cycle
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        grant_id   = '0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && (req0_valid || req1_valid)) begin
                    accept = 1'b1;
                    if (req0_valid && req1_valid) begin
                        grant_id = (PRIO_FIXED != 0) ? ID_W'(0) : ~last_grant;
                    end else begin
                        grant_id = req1_valid ? ID_W'(1) : ID_W'(0);
                    end
                    req0_ready = (grant_id == ID_W'(0));
                    req1_ready = (grant_id == ID_W'(1));
                    next_state = EXEC;
                end
            end
            EXEC: next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        if (grant_id == ID_W'(1)) begin
            sel = '{a: req1_a, b: req1_b, op: req1_op, id: ID_W'(1)};
        end else begin
            sel = '{a: req0_a, b: req0_b, op: req0_op, id: ID_W'(0)};
        end
    end

    adder_subtractor_8bit u_alu (
        .a    (held.a),
        .b    (held.b),
        .op   (held.op),
        .sum  (alu_sum),
        .cout (alu_cout)
    );

    // Operand capture, grant pointer and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= ID_W'(1);
            held       <= '0;
            rsp_valid  <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_id     <= '0;
        end else begin
            if (accept) begin
                held       <= sel;
                last_grant <= grant_id;
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_sum   <= alu_sum;
                rsp_cout  <= alu_cout;
                rsp_id    <= held.id;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ADDSUB_ARB_OVF_EN
    // Signed overflow: operands of equal sign producing a result of the other sign
    logic ovf_c;
    assign ovf_c = (held.a[DATA_W-1] == (held.b[DATA_W-1] ^ held.op)) &&
                   (alu_sum[DATA_W-1] != held.a[DATA_W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_ovf <= 1'b0;
        end else if (state == EXEC) begin
            rsp_ovf <= ovf_c;
        end
    end
`endif

endmodule
